// File: rtl/square_anim_ctrl_pkg.sv
// Shared types and defaults for the square animation controller.
package sq_anim_pkg;

    localparam int H_RES_DEF = 640;
    localparam int V_RES_DEF = 480;

    typedef enum logic [1:0] {IDLE, CALC, COMMIT} state_t;

    typedef enum logic {DIR_POS = 1'b0, DIR_NEG = 1'b1} dir_t;

    function automatic dir_t dir_flip(input dir_t d);
        return (d == DIR_POS) ? DIR_NEG : DIR_POS;
    endfunction

endpackage

// File: rtl/square_anim_ctrl_if.sv
// Configuration handshake between software-side master and the animation controller.
interface square_anim_ctrl_if #(
    parameter int CORDW = 10,
    parameter int SPDW  = 4
) ();
    logic             cfg_valid;
    logic             cfg_ready;
    logic [CORDW-1:0] cfg_size;
    logic [SPDW-1:0]  cfg_dx;
    logic [SPDW-1:0]  cfg_dy;

    modport master (output cfg_valid, cfg_size, cfg_dx, cfg_dy, input cfg_ready);
    modport slave  (input cfg_valid, cfg_size, cfg_dx, cfg_dy, output cfg_ready);
endinterface

// File: rtl/square_anim_ctrl_axis_step.sv
// One-axis bounce step: advances pos by mag in dir, stopping at 0 or limit-size and reversing there.
module square_axis_step
    import sq_anim_pkg::*;
#(
    parameter int CORDW = 10,
    parameter int SPDW  = 4
) (
    input  logic [CORDW-1:0] i_pos,
    input  logic [SPDW-1:0]  i_mag,
    input  dir_t             i_dir,
    input  logic [CORDW-1:0] i_size,
    input  logic [CORDW-1:0] i_limit,
    output logic [CORDW-1:0] o_pos,
    output dir_t             o_dir
);

    logic [CORDW:0] w_sum;
    logic [CORDW:0] w_edge;
    logic [CORDW:0] w_mag;

    always_comb begin
        w_mag  = (CORDW+1)'(i_mag);
        w_sum  = {1'b0, i_pos} + w_mag;
        w_edge = {1'b0, i_limit} - {1'b0, i_size};
        o_pos  = i_pos;
        o_dir  = i_dir;
        if (i_mag != '0) begin
            if (i_dir == DIR_POS) begin
                if (w_sum >= w_edge) begin
                    o_pos = w_edge[CORDW-1:0];
                    o_dir = dir_flip(i_dir);
                end else begin
                    o_pos = w_sum[CORDW-1:0];
                end
            end else begin
                if ({1'b0, i_pos} <= w_mag) begin
                    o_pos = '0;
                    o_dir = dir_flip(i_dir);
                end else begin
                    o_pos = i_pos - CORDW'(i_mag);
                end
            end
        end
    end

endmodule

// File: rtl/square_anim_ctrl.sv
// Frame-synchronous square controller: double-buffered position/size, motion applied in vertical blanking.
// state  | meaning
// IDLE   | drawing; config accepted into pending
// CALC   | motion and pending config computed into shadow regs
// COMMIT | shadow copied to active regs, frame counter advanced
module square_anim_ctrl
    import sq_anim_pkg::*;
#(
    parameter int CORDW     = 10,
    parameter int H_RES     = H_RES_DEF,
    parameter int V_RES     = V_RES_DEF,
    parameter int SPDW      = 4,
    parameter int X_INIT    = 220,
    parameter int Y_INIT    = 140,
    parameter int SIZE_INIT = 200
) (
    input  logic             clk_pix,
    input  logic             rst_pix,
    input  logic [CORDW-1:0] sx,
    input  logic [CORDW-1:0] sy,
    square_anim_ctrl_if.slave cfg,
    input  logic             pause,
    input  logic             step,
    output logic             square,
    output logic [CORDW-1:0] sq_x,
    output logic [CORDW-1:0] sq_y,
    output logic [15:0]      frame_cnt,
    output logic             busy
);

    localparam logic [CORDW-1:0] LIM_X = CORDW'(H_RES);
    localparam logic [CORDW-1:0] LIM_Y = CORDW'(V_RES);

    state_t           r_state, w_state_nxt;
    logic [CORDW-1:0] r_x, r_y, r_size;
    logic [SPDW-1:0]  r_dx, r_dy;
    dir_t             r_dir_x, r_dir_y;
    logic [CORDW-1:0] r_sh_x, r_sh_y, r_sh_size;
    logic [SPDW-1:0]  r_sh_dx, r_sh_dy;
    dir_t             r_sh_dir_x, r_sh_dir_y;
    logic             r_pend_full;
    logic [CORDW-1:0] r_pend_size;
    logic [SPDW-1:0]  r_pend_dx, r_pend_dy;
    logic             r_step;
    logic             r_square;
    logic [15:0]      r_frame_cnt;

    logic             w_frame_evt, w_cfg_ready, w_cfg_acc, w_move, w_in_sq;
    logic [CORDW-1:0] w_cfg_size, w_nx_x, w_nx_y, w_fit_x, w_fit_y;
    dir_t             w_nx_dir_x, w_nx_dir_y;

    assign w_frame_evt   = (sy == LIM_Y) && (sx == '0);
    assign w_cfg_ready   = !r_pend_full && (r_state == IDLE);
    assign w_cfg_acc     = cfg.cfg_valid && w_cfg_ready;
    assign cfg.cfg_ready = w_cfg_ready;
    assign w_move        = !pause || r_step;

    always_comb begin
        w_cfg_size = cfg.cfg_size;
        if (cfg.cfg_size == '0)        w_cfg_size = CORDW'(1);
        else if (cfg.cfg_size > LIM_Y) w_cfg_size = LIM_Y;
    end

    square_axis_step #(.CORDW(CORDW), .SPDW(SPDW)) u_step_x (
        .i_pos(r_x), .i_mag(r_dx), .i_dir(r_dir_x), .i_size(r_size), .i_limit(LIM_X),
        .o_pos(w_nx_x), .o_dir(w_nx_dir_x)
    );

    square_axis_step #(.CORDW(CORDW), .SPDW(SPDW)) u_step_y (
        .i_pos(r_y), .i_mag(r_dy), .i_dir(r_dir_y), .i_size(r_size), .i_limit(LIM_Y),
        .o_pos(w_nx_y), .o_dir(w_nx_dir_y)
    );

    // A larger new size can push the square past the far edge; pull it back in.
    assign w_fit_x = (({1'b0, r_sh_x} + {1'b0, r_sh_size}) > {1'b0, LIM_X}) ? (LIM_X - r_sh_size) : r_sh_x;
    assign w_fit_y = (({1'b0, r_sh_y} + {1'b0, r_sh_size}) > {1'b0, LIM_Y}) ? (LIM_Y - r_sh_size) : r_sh_y;

    assign w_in_sq = (sx >= r_x) && ({1'b0, sx} < ({1'b0, r_x} + {1'b0, r_size})) &&
                     (sy >= r_y) && ({1'b0, sy} < ({1'b0, r_y} + {1'b0, r_size}));

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_frame_evt) w_state_nxt = CALC;
            CALC:    w_state_nxt = COMMIT;
            COMMIT:  w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_pix or posedge rst_pix) begin
        if (rst_pix) r_state <= IDLE;
        else         r_state <= w_state_nxt;
    end

    always_ff @(posedge clk_pix or posedge rst_pix) begin
        if (rst_pix) begin
            r_pend_full <= 1'b0;
            r_pend_size <= '0;
            r_pend_dx   <= '0;
            r_pend_dy   <= '0;
        end else if (w_cfg_acc) begin
            r_pend_full <= 1'b1;
            r_pend_size <= w_cfg_size;
            r_pend_dx   <= cfg.cfg_dx;
            r_pend_dy   <= cfg.cfg_dy;
        end else if (r_state == CALC) begin
            r_pend_full <= 1'b0;
        end
    end

    always_ff @(posedge clk_pix or posedge rst_pix) begin
        if (rst_pix) begin
            r_sh_x     <= CORDW'(X_INIT);
            r_sh_y     <= CORDW'(Y_INIT);
            r_sh_size  <= CORDW'(SIZE_INIT);
            r_sh_dx    <= SPDW'(1);
            r_sh_dy    <= SPDW'(1);
            r_sh_dir_x <= DIR_POS;
            r_sh_dir_y <= DIR_POS;
        end else if (r_state == CALC) begin
            r_sh_x     <= w_move ? w_nx_x : r_x;
            r_sh_y     <= w_move ? w_nx_y : r_y;
            r_sh_dir_x <= w_move ? w_nx_dir_x : r_dir_x;
            r_sh_dir_y <= w_move ? w_nx_dir_y : r_dir_y;
            r_sh_size  <= r_pend_full ? r_pend_size : r_size;
            r_sh_dx    <= r_pend_full ? r_pend_dx : r_dx;
            r_sh_dy    <= r_pend_full ? r_pend_dy : r_dy;
        end
    end

    always_ff @(posedge clk_pix or posedge rst_pix) begin
        if (rst_pix) begin
            r_x         <= CORDW'(X_INIT);
            r_y         <= CORDW'(Y_INIT);
            r_size      <= CORDW'(SIZE_INIT);
            r_dx        <= SPDW'(1);
            r_dy        <= SPDW'(1);
            r_dir_x     <= DIR_POS;
            r_dir_y     <= DIR_POS;
            r_frame_cnt <= '0;
        end else if (r_state == COMMIT) begin
            r_x         <= w_fit_x;
            r_y         <= w_fit_y;
            r_size      <= r_sh_size;
            r_dx        <= r_sh_dx;
            r_dy        <= r_sh_dy;
            r_dir_x     <= r_sh_dir_x;
            r_dir_y     <= r_sh_dir_y;
            r_frame_cnt <= r_frame_cnt + 16'd1;
        end
    end

    // A step arriving during COMMIT belongs to the next frame, so set wins over clear.
    always_ff @(posedge clk_pix or posedge rst_pix) begin
        if (rst_pix)                 r_step <= 1'b0;
        else if (step)               r_step <= 1'b1;
        else if (r_state == COMMIT)  r_step <= 1'b0;
    end

    always_ff @(posedge clk_pix or posedge rst_pix) begin
        if (rst_pix) r_square <= 1'b0;
        else         r_square <= w_in_sq;
    end

    assign square    = r_square;
    assign sq_x      = r_x;
    assign sq_y      = r_y;
    assign frame_cnt = r_frame_cnt;
    assign busy      = (r_state != IDLE);

endmodule
